// File: rtl/maf_pkg.sv
// maf_pkg: shared widths, sign-flag bit positions and the stage occupancy enum.
package maf_pkg;
  localparam int DEF_LEVEL_W = 288;
  localparam int DEF_EXP_W = 12;
  localparam int DEF_CONT_W = 3;
  localparam int DEF_NSIGN = 6;
  localparam int DEF_CNT_W = 16;
  localparam int S_A = 0;
  localparam int S_B = 1;
  localparam int S_C = 2;
  localparam int S_A_H = 3;
  localparam int S_B_H = 4;
  localparam int S_C_H = 5;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/maf_stage_slot.sv
// maf_stage_slot: payload register bundle with load enable and synchronous clear.
module maf_stage_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (load) q <= data;
endmodule

// File: rtl/maf_stage_reg.sv
// maf_stage_reg: two-entry skid pipeline register for the MAF partial-product stage.
module maf_stage_reg
  import maf_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int EXP_W = DEF_EXP_W,
  parameter int CONT_W = DEF_CONT_W,
  parameter int NSIGN = DEF_NSIGN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic [NSIGN-1:0]   sign_in,
  input  logic [CONT_W-1:0]  cont_in,
  input  logic [EXP_W-1:0]   d_in,
  input  logic [EXP_W-1:0]   e_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] level_out,
  output logic [NSIGN-1:0]   sign_out,
  output logic [CONT_W-1:0]  cont_out,
  output logic [EXP_W-1:0]   d_out,
  output logic [EXP_W-1:0]   e_out,
  output logic [CNT_W-1:0]   stall_cnt
);
  localparam int PW = LEVEL_W + NSIGN + CONT_W + 2 * EXP_W;
  state_t state, state_nx;
  logic xin, xout, main_load, skid_load;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  assign in_pl = {level_in, sign_in, cont_in, d_in, e_in};
  assign {level_out, sign_out, cont_out, d_out, e_out} = main_q;
  assign xin = in_valid && in_ready;
  assign xout = out_valid && out_ready;
  // in_ready is registered from the next state so it never depends on out_ready
  always_ff @(posedge clk)
    if (rst) begin
      state <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state <= state_nx;
      in_ready <= state_nx != TWO;
    end
  always_comb begin
    state_nx = state;
    if (flush) state_nx = EMPTY;
    else
      case (state)
        EMPTY: state_nx = xin ? ONE : EMPTY;
        ONE: state_nx = (xin && !xout) ? TWO : (!xin && xout) ? EMPTY : ONE;
        TWO: state_nx = xout ? ONE : TWO;
        default: state_nx = EMPTY;
      endcase
  end
  always_comb begin
    out_valid = state != EMPTY;
    main_load = !flush && (state == TWO ? xout : state == ONE ? xin && xout : xin);
    skid_load = !flush && state == ONE && xin && !xout;
    main_d = state == TWO ? skid_q : in_pl;
  end
  always_ff @(posedge clk)
    if (rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  maf_stage_slot #(.W(PW)) u_main (
    .clk(clk), .clr(rst), .load(main_load), .data(main_d), .q(main_q)
  );
  maf_stage_slot #(.W(PW)) u_skid (
    .clk(clk), .clr(rst), .load(skid_load), .data(in_pl), .q(skid_q)
  );
endmodule

// File: tb/tb_maf_stage_reg.sv
// tb_maf_stage_reg: directed stimulus with a FIFO scoreboard checked by a separate monitor.
module tb_maf_stage_reg;
  typedef struct packed {
    logic [287:0] level;
    logic [5:0] sign;
    logic [2:0] cont;
    logic [11:0] d;
    logic [11:0] e;
  } pl_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [287:0] level_in = '0;
  logic [5:0] sign_in = '0;
  logic [2:0] cont_in = '0;
  logic [11:0] d_in = '0, e_in = '0;
  logic in_ready, out_valid;
  logic [287:0] level_out;
  logic [5:0] sign_out;
  logic [2:0] cont_out;
  logic [11:0] d_out, e_out;
  logic [15:0] stall_cnt;
  logic s_rst = 1, s_in_valid = 0, s_out_ready = 0;
  logic s_in_ready, s_out_valid;
  logic [7:0] s_level_out;
  logic [5:0] s_sign_out;
  logic [2:0] s_cont_out;
  logic [11:0] s_d_out, s_e_out;
  logic [3:0] s_stall_cnt;
  int n_cmp = 0, n_fail = 0;
  pl_t exp_q[$];
  pl_t got, want;
  always #5 clk = ~clk;
  maf_stage_reg u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .level_in(level_in), .sign_in(sign_in), .cont_in(cont_in), .d_in(d_in), .e_in(e_in),
    .out_valid(out_valid), .out_ready(out_ready), .level_out(level_out), .sign_out(sign_out),
    .cont_out(cont_out), .d_out(d_out), .e_out(e_out), .stall_cnt(stall_cnt)
  );
  maf_stage_reg #(.LEVEL_W(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(s_rst), .flush(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .level_in(8'h5A), .sign_in(6'h15), .cont_in(3'h2), .d_in(12'h123), .e_in(12'h456),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .level_out(s_level_out), .sign_out(s_sign_out),
    .cont_out(s_cont_out), .d_out(s_d_out), .e_out(s_e_out), .stall_cnt(s_stall_cnt)
  );
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [287:0] lv, input logic [11:0] d);
    in_valid = 1;
    level_in = lv;
    d_in = d;
    sign_in = d[5:0];
    cont_in = d[2:0];
    e_in = ~d;
  endtask
  // Monitor: inputs are stable at the falling edge, so it sees exactly what the next rising edge will do
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      got = '{level_out, sign_out, cont_out, d_out, e_out};
      if (exp_q.size() == 0) check("unexpected_out", got, '0);
      else begin
        want = exp_q.pop_front();
        check("sb_payload", got, want);
      end
    end
    if (!rst && !flush && in_valid && in_ready)
      exp_q.push_back('{level_in, sign_in, cont_in, d_in, e_in});
    if (rst || flush) exp_q.delete();
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level_out", level_out, 0);
    check("rst_d_out", d_out, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    tick();
    rst = 0;
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      put(288'(i * 16'h1111), 12'(i));
      tick();
      check("stream_out_valid", out_valid, 1);
      check("stream_d_out", d_out, i);
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 0;
    tick();
    check("stream_drained", out_valid, 0);
    out_ready = 0;
    put(288'hA, 12'h0A);
    tick();
    check("bp_ready_after_a", in_ready, 1);
    put(288'hB, 12'h0B);
    tick();
    check("bp_ready_after_b", in_ready, 0);
    check("bp_stall_1", stall_cnt, 1);
    put(288'hC, 12'h0C);
    tick();
    tick();
    check("bp_hold_ready", in_ready, 0);
    check("bp_hold_level", level_out, 288'hA);
    check("bp_stall_3", stall_cnt, 3);
    out_ready = 1;
    tick();
    check("bp_rel_level_b", level_out, 288'hB);
    check("bp_rel_ready", in_ready, 1);
    tick();
    check("bp_rel_level_c", level_out, 288'hC);
    in_valid = 0;
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_stall_final", stall_cnt, 3);
    out_ready = 0;
    put(288'hD1, 12'hD1);
    tick();
    put(288'hD2, 12'hD2);
    tick();
    check("fl_two", in_ready, 0);
    check("fl_stall_before", stall_cnt, 4);
    put(288'hEE, 12'hEE);
    flush = 1;
    out_ready = 1;
    tick();
    flush = 0;
    in_valid = 0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_stall_kept", stall_cnt, 4);
    tick();
    check("fl_still_empty", out_valid, 0);
    put(288'hF0, 12'hF0);
    tick();
    in_valid = 0;
    check("fl_next_item", level_out, 288'hF0);
    tick();
    out_ready = 0;
    put(288'h71, 12'h71);
    tick();
    put(288'h72, 12'h72);
    tick();
    in_valid = 0;
    check("rs_two", in_ready, 0);
    rst = 1;
    tick();
    rst = 0;
    check("rs_out_valid", out_valid, 0);
    check("rs_in_ready", in_ready, 1);
    check("rs_level", level_out, 0);
    check("rs_fields", {sign_out, cont_out, d_out, e_out}, 0);
    check("rs_stall", stall_cnt, 0);
    out_ready = 1;
    in_valid = 1;
    level_in = 288'h1234;
    sign_in = 6'b101010;
    cont_in = 3'b101;
    d_in = 12'h321;
    e_in = 12'hABC;
    tick();
    in_valid = 0;
    check("def_sign", sign_out, 6'b101010);
    check("def_cont", cont_out, 3'b101);
    check("def_e", e_out, 12'hABC);
    tick();
    s_rst = 0;
    s_in_valid = 1;
    tick();
    s_in_valid = 0;
    check("sat_valid", s_out_valid, 1);
    repeat (14) tick();
    check("sat_14", s_stall_cnt, 14);
    repeat (6) tick();
    check("sat_15", s_stall_cnt, 15);
    check("sat_payload", {s_level_out, s_d_out}, {8'h5A, 12'h123});
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/maf_stage_reg.md
MAF_STAGE_REG -- requirements
Module: maf_stage_reg

Interface
REQ-001 Parameter LEVEL_W, default 288, width of partial-product level bus.
REQ-002 Parameter EXP_W, default 12, width of d and E fields.
REQ-003 Parameter CONT_W, default 3, width of control code.
REQ-004 Parameter NSIGN, default 6, number of sign flags (S_A, S_B, S_C, S_A_H, S_B_H, S_C_H in that bit order, LSB first).
REQ-005 Parameter CNT_W, default 16, width of stall counter.
REQ-006 clk  in  1  sole clock, all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high; one clock; reset is synchronous and active-high.
REQ-008 flush  in  1  discard all held entries.
REQ-009 in_valid  in  1  upstream payload valid.
REQ-010 in_ready  out  1  stage accepts payload this cycle.
REQ-011 level_in  in  LEVEL_W; sign_in  in  NSIGN; cont_in  in  CONT_W; d_in  in  EXP_W; e_in  in  EXP_W  upstream payload.
REQ-012 out_valid  out  1  downstream payload valid.
REQ-013 out_ready  in  1  downstream accepts payload.
REQ-014 level_out, sign_out, cont_out, d_out, e_out  out  widths as REQ-011  registered payload.
REQ-015 stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-017 Storage: main slot (drives outputs) plus one skid slot; states EMPTY (0 held), ONE (main held), TWO (main+skid held).
REQ-018 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in TWO; never combinationally dependent on out_ready.
REQ-019 EMPTY: transfer in -> ONE, main loads input.
REQ-020 ONE: in only -> TWO (skid loads); out only -> EMPTY; in and out -> ONE, main loads input; neither -> ONE.
REQ-021 TWO: transfer out -> ONE, main loads skid contents; otherwise hold.
REQ-022 Latency: payload accepted in cycle N appears on outputs in cycle N+1 when stage was EMPTY or draining; throughput one item per cycle with out_ready held high.
REQ-023 Ordering strictly FIFO; no payload lost or duplicated.
REQ-024 out_valid = 1 exactly in ONE and TWO; payload outputs hold stable while out_valid=1 and out_ready=0.
REQ-025 flush=1: next state EMPTY, in_ready=1 next cycle, any same-cycle input dropped; flush has priority over all transfers; stall_cnt unaffected.
REQ-026 stall_cnt increments by 1 per stall cycle, saturates at all-ones, never wraps.
REQ-027 Payload registers load only on enable; not cleared by flush (contents don't-care while out_valid=0).

Reset
REQ-028 rst=1 at a rising edge: state EMPTY, out_valid=0, in_ready=1 from next cycle, all payload outputs 0, stall_cnt 0.
REQ-029 rst asserted mid-operation discards held entries; rst has priority over flush and transfers.

Structure
REQ-030 Shared package maf_pkg holds LEVEL_W/EXP_W/CONT_W/NSIGN defaults, sign-bit index constants, and state enum {EMPTY, ONE, TWO}.
REQ-031 One sub-module maf_stage_slot (payload register bundle with load enable and synchronous clear), instantiated twice (main, skid).

Verification
REQ-032 Streaming: out_ready=1, 8 back-to-back items d_in=1..8 -> d_out=1..8 on consecutive cycles, one cycle after each accept, in_ready constantly 1.
REQ-033 Backpressure: out_ready=0, push 3 items (level_in=A,B,C) -> A,B accepted, in_ready=0 after second, C held upstream; release out_ready -> A,B,C in order, stall_cnt equals stalled cycle count.
REQ-034 Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and same-cycle items never appear.
REQ-035 Reset mid-stream in TWO -> next cycle all outputs 0, out_valid=0, stall_cnt=0.
REQ-036 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-037 Default-parameter build: sign_in=6'b101010, cont_in=3'b101, e_in=12'hABC -> identical values on outputs one cycle later.
